// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - MDU operation codes and op-class helpers shared across the pipeline
package e_mdu_pkg;

  localparam int MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd8;

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_arith(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// rtl/e_mdu_if.sv - Execute-stage request/response bundle between pipeline and MDU
interface e_mdu_if;
  import e_mdu_pkg::*;

  logic               md_start;
  logic [MD_OP_W-1:0] md_op;
  logic [31:0]        md_rs;
  logic [31:0]        md_rt;
  logic               md_d_is_md;
  logic [31:0]        md_rdata;
  logic               md_busy;
  logic               md_stall_req;

  modport master (
    output md_start, md_op, md_rs, md_rt, md_d_is_md,
    input  md_rdata, md_busy, md_stall_req
  );

  modport slave (
    input  md_start, md_op, md_rs, md_rt, md_d_is_md,
    output md_rdata, md_busy, md_stall_req
  );

endinterface

// File: rtl/e_mdu_arith.sv
// rtl/e_mdu_arith.sv - combinational multiply/divide datapath on the latched operands
module mdu_arith
  import e_mdu_pkg::*;
(
  input  logic [MD_OP_W-1:0] op_i,
  input  logic [31:0]        rs_i,
  input  logic [31:0]        rt_i,
  output logic [31:0]        res_hi_o,
  output logic [31:0]        res_lo_o,
  output logic               div_by_zero_o
);

  logic [63:0] prod;

  assign div_by_zero_o = md_is_div(op_i) && (rt_i == 32'd0);

  always_comb begin
    prod     = 64'd0;
    res_hi_o = 32'd0;
    res_lo_o = 32'd0;
    case (op_i)
      MD_MULT: begin
        prod = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
        {res_hi_o, res_lo_o} = prod;
      end
      MD_MULTU: begin
        prod = {32'd0, rs_i} * {32'd0, rt_i};
        {res_hi_o, res_lo_o} = prod;
      end
      MD_DIV: begin
        // The one signed overflow case is pinned explicitly rather than left to the divider.
        if (rt_i == 32'd0) begin
          res_hi_o = 32'd0;
        end else if (rs_i == 32'h8000_0000 && rt_i == 32'hFFFF_FFFF) begin
          res_lo_o = 32'h8000_0000;
          res_hi_o = 32'd0;
        end else begin
          res_lo_o = $signed(rs_i) / $signed(rt_i);
          res_hi_o = $signed(rs_i) % $signed(rt_i);
        end
      end
      MD_DIVU: begin
        if (rt_i != 32'd0) begin
          res_lo_o = rs_i / rt_i;
          res_hi_o = rs_i % rt_i;
        end
      end
      default: begin
        prod = 64'd0;
      end
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - fixed-latency multiply/divide unit with HI/LO registers and stall request
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic     clk,
  input  logic     reset,
  e_mdu_if.slave   md
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        rs_q, rs_d, rt_q, rt_d;
  logic [MD_OP_W-1:0] op_q, op_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d;

  logic [31:0]        res_hi, res_lo;
  logic               div_by_zero;

  mdu_arith u_arith (
    .op_i          (op_q),
    .rs_i          (rs_q),
    .rt_i          (rt_q),
    .res_hi_o      (res_hi),
    .res_lo_o      (res_lo),
    .div_by_zero_o (div_by_zero)
  );

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    rs_d   = rs_q;
    rt_d   = rt_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      // Any md_start arriving while busy is dropped here, not queued.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        if (!div_by_zero) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
    end else if (md.md_start) begin
      if (md_is_arith(md.md_op)) begin
        rs_d   = md.md_rs;
        rt_d   = md.md_rt;
        op_d   = md.md_op;
        cnt_d  = md_is_div(md.md_op) ? DIV_CNT : MUL_CNT;
        busy_d = 1'b1;
      end else if (md.md_op == MD_MTHI) begin
        hi_d = md.md_rs;
      end else if (md.md_op == MD_MTLO) begin
        lo_d = md.md_rs;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      rs_q   <= 32'd0;
      rt_q   <= 32'd0;
      op_q   <= MD_NONE;
      cnt_q  <= 4'd0;
      busy_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    md.md_rdata = 32'd0;
    if (md.md_start && md.md_op == MD_MFHI) md.md_rdata = hi_q;
    else if (md.md_start && md.md_op == MD_MFLO) md.md_rdata = lo_q;
  end

  assign md.md_busy      = busy_q;
  assign md.md_stall_req = (busy_q | (md.md_start & md_is_arith(md.md_op))) & md.md_d_is_md;

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - scoreboard bench for e_mdu
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  e_mdu_if md_bus();

  e_mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    md_bus.md_start = 1'b0;
    md_bus.md_op    = MD_NONE;
    md_bus.md_rs    = 32'd0;
    md_bus.md_rt    = 32'd0;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    md_bus.md_start = 1'b1;
    md_bus.md_op    = MD_MFHI;
    #1 hi = md_bus.md_rdata;
    md_bus.md_op    = MD_MFLO;
    #1 lo = md_bus.md_rdata;
    idle();
    step();
  endtask

  task automatic do_mt(input logic [MD_OP_W-1:0] op, input logic [31:0] val);
    md_bus.md_start = 1'b1;
    md_bus.md_op    = op;
    md_bus.md_rs    = val;
    step();
    idle();
  endtask

  task automatic run_arith(input string tag, input logic [MD_OP_W-1:0] op,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input int n, input logic d_is_md,
                           input logic inj_start, input logic [MD_OP_W-1:0] inj_op,
                           input logic [31:0] inj_val, input logic [63:0] expect_hilo);
    int cycles = 0;
    logic [31:0] hi, lo;
    logic [63:0] e;
    md_bus.md_d_is_md = d_is_md;
    md_bus.md_start   = 1'b1;
    md_bus.md_op      = op;
    md_bus.md_rs      = rs;
    md_bus.md_rt      = rt;
    exp_q.push_back(expect_hilo);
    #1 chk({tag, "_stall_issue"}, 64'(md_bus.md_stall_req), 64'(d_is_md));
    step();
    idle();
    while (md_bus.md_busy && cycles < 40) begin
      chk({tag, "_stall_busy"}, 64'(md_bus.md_stall_req), 64'(d_is_md));
      cycles++;
      if (cycles == 2) begin
        md_bus.md_start = inj_start;
        md_bus.md_op    = inj_op;
        md_bus.md_rs    = inj_val;
        md_bus.md_rt    = inj_val;
      end else if (cycles == 3) begin
        idle();
      end
      step();
    end
    idle();
    chk({tag, "_busy_len"}, 64'(cycles), 64'(n));
    chk({tag, "_stall_after"}, 64'(md_bus.md_stall_req), 64'd0);
    read_hilo(hi, lo);
    e = exp_q.pop_front();
    chk({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
    chk({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
    md_bus.md_d_is_md = 1'b0;
  endtask

  initial begin
    logic [31:0] hi, lo;
    int c;
    idle();
    md_bus.md_d_is_md = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    chk("rst_busy", 64'(md_bus.md_busy), 64'd0);
    chk("rst_stall", 64'(md_bus.md_stall_req), 64'd0);
    read_hilo(hi, lo);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    run_arith("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7, 5, 1'b0, 1'b0, MD_NONE, 32'd0,
              64'hFFFF_FFFF_FFFF_FFEB);
    run_arith("divu_100_7", MD_DIVU, 32'd100, 32'd7, 10, 1'b0, 1'b0, MD_NONE, 32'd0,
              {32'd2, 32'd14});
    run_arith("div_neg7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, 1'b0, MD_NONE, 32'd0,
              {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_arith("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 1'b0, MD_NONE, 32'd0,
              {32'd0, 32'h8000_0000});
    run_arith("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0, 1'b0, MD_NONE, 32'd0,
              64'hFFFF_FFFE_0000_0001);
    run_arith("divu_big", MD_DIVU, 32'hFFFF_FFFF, 32'h10, 10, 1'b0, 1'b0, MD_NONE, 32'd0,
              {32'hF, 32'h0FFF_FFFF});
    run_arith("div_pos_neg", MD_DIV, 32'd7, 32'hFFFF_FFFE, 10, 1'b0, 1'b0, MD_NONE, 32'd0,
              {32'd1, 32'hFFFF_FFFD});

    do_mt(MD_MTHI, 32'h1234);
    read_hilo(hi, lo);
    chk("mthi_hi", 64'(hi), 64'h1234);
    run_arith("multu_mthi_inj", MD_MULTU, 32'd3, 32'd4, 5, 1'b0, 1'b1, MD_MTHI, 32'h5555,
              {32'd0, 32'd12});
    run_arith("multu_multu_inj", MD_MULTU, 32'd3, 32'd4, 5, 1'b0, 1'b1, MD_MULTU, 32'd7,
              {32'd0, 32'd12});

    do_mt(MD_MTHI, 32'hA);
    do_mt(MD_MTLO, 32'hB);
    run_arith("div_by_zero", MD_DIV, 32'd50, 32'd0, 10, 1'b0, 1'b0, MD_NONE, 32'd0,
              {32'hA, 32'hB});
    run_arith("divu_by_zero", MD_DIVU, 32'd50, 32'd0, 10, 1'b0, 1'b0, MD_NONE, 32'd0,
              {32'hA, 32'hB});

    do_mt(4'd12, 32'hDEAD);
    read_hilo(hi, lo);
    chk("badop_hi", 64'(hi), 64'hA);
    chk("badop_lo", 64'(lo), 64'hB);

    run_arith("div_stall", MD_DIV, 32'd20, 32'd3, 10, 1'b1, 1'b0, MD_NONE, 32'd0,
              {32'd2, 32'd6});
    run_arith("div_nostall", MD_DIV, 32'd20, 32'd3, 10, 1'b0, 1'b0, MD_NONE, 32'd0,
              {32'd2, 32'd6});

    md_bus.md_d_is_md = 1'b1;
    md_bus.md_start   = 1'b1;
    md_bus.md_op      = MD_DIVU;
    md_bus.md_rs      = 32'd9;
    md_bus.md_rt      = 32'd2;
    step();
    idle();
    c = 1;
    while (c < 3) begin
      step();
      c++;
    end
    chk("rstmid_busy_before", 64'(md_bus.md_busy), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_busy", 64'(md_bus.md_busy), 64'd0);
    chk("rstmid_stall", 64'(md_bus.md_stall_req), 64'd0);
    read_hilo(hi, lo);
    chk("rstmid_hi", 64'(hi), 64'd0);
    chk("rstmid_lo", 64'(lo), 64'd0);
    md_bus.md_d_is_md = 1'b0;
    run_arith("multu_after_rst", MD_MULTU, 32'd2, 32'd2, 5, 1'b0, 1'b0, MD_NONE, 32'd0,
              {32'd0, 32'd4});

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
